// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: arbiter state encoding,
// port-index constants and the processor state constants.
package mem_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arbState_t;

  // Instruction fetch sits on port 0, the debug loader on port 1
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    CPU_RESET = 2'd0,
    CPU_FETCH = 2'd1,
    CPU_EXEC  = 2'd2,
    CPU_HALT  = 2'd3
  } cpuState_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports plus the memory-side bus of the arbiter.
// The arbiter uses the slave view; requesters and memory use the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic              p0_we;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic [ADDR_W-1:0] p1_addr;
  logic              p1_we;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_lock;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_strobe;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_addr, p0_we, p0_wdata,
    input  p1_req, p1_addr, p1_we, p1_wdata, p1_lock,
    input  mem_rdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_addr, mem_strobe, mem_we, mem_wdata
  );

  modport master (
    output p0_req, p0_addr, p0_we, p0_wdata,
    output p1_req, p1_addr, p1_we, p1_wdata, p1_lock,
    output mem_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_addr, mem_strobe, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Pure two-way round-robin selector: on a conflict the port that did not
// own the memory last wins; a lone requester always wins.
module mem_arbiter_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb begin
    grant = req;
    if (&req) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a synchronous single-port memory. Grants are
// combinational, read data returns one cycle later; port 1 can lock the bus.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic clk,
  input  logic reset_n,
  mem_arbiter_if.slave bus
);
  arbState_t         stateReg, stateNext;
  logic              lastOwnerReg;
  logic [1:0]        rvalidReg;
  logic [1:0]        reqVec, rrGrant, gntVec, rvalidOut;
  logic              lockHeld;
  logic [ADDR_W-1:0] addrMux;
  logic [DATA_W-1:0] wdataMux;

  assign reqVec = {bus.p1_req, bus.p0_req};
  // Lock only holds while p1_lock stays high; the release cycle arbitrates normally
  assign lockHeld = (stateReg == LOCKED) && bus.p1_lock;

  mem_arbiter_rr_pick rrPick (
    .req  (reqVec),
    .last (lastOwnerReg),
    .grant(rrGrant)
  );

  always_comb begin
    gntVec    = 2'b00;
    stateNext = stateReg;
    if (lockHeld) begin
      gntVec = {bus.p1_req, 1'b0};
    end else if (FIXED_PRIO != 0) begin
      gntVec = bus.p0_req ? 2'b01 : reqVec;
    end else begin
      gntVec = rrGrant;
    end
    if (!reset_n) begin
      gntVec = 2'b00;
    end
    if (gntVec[PORT_DBG] && bus.p1_lock) begin
      stateNext = LOCKED;
    end else if (!bus.p1_lock) begin
      stateNext = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stateReg     <= IDLE;
      lastOwnerReg <= PORT_DBG;
      rvalidReg    <= 2'b00;
    end else begin
      stateReg <= stateNext;
      if (gntVec[PORT_CPU]) begin
        lastOwnerReg <= PORT_CPU;
      end else if (gntVec[PORT_DBG]) begin
        lastOwnerReg <= PORT_DBG;
      end
      rvalidReg <= gntVec & ~{bus.p1_we, bus.p0_we};
    end
  end

  // A read return still in flight when reset arrives is dropped immediately
  assign rvalidOut = rvalidReg & {2{reset_n}};

  assign addrMux  = gntVec[PORT_DBG] ? bus.p1_addr  : bus.p0_addr;
  assign wdataMux = gntVec[PORT_DBG] ? bus.p1_wdata : bus.p0_wdata;

  assign bus.mem_addr   = addrMux;
  assign bus.mem_wdata  = wdataMux;
  assign bus.mem_we     = gntVec[PORT_DBG] ? bus.p1_we : bus.p0_we;
  assign bus.mem_strobe = |gntVec;

  assign bus.p0_gnt    = gntVec[PORT_CPU];
  assign bus.p1_gnt    = gntVec[PORT_DBG];
  assign bus.p0_rvalid = rvalidOut[PORT_CPU];
  assign bus.p1_rvalid = rvalidOut[PORT_DBG];
  assign bus.p0_rdata  = rvalidOut[PORT_CPU] ? bus.mem_rdata : '0;
  assign bus.p1_rdata  = rvalidOut[PORT_DBG] ? bus.mem_rdata : '0;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = port 0 always wins.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 pN_req  in  1  port N (N=0,1) request; held with its address and data until granted.
REQ-007 pN_addr  in  ADDR_W  port N address.
REQ-008 pN_we  in  1  port N write (1) / read (0).
REQ-009 pN_wdata  in  DATA_W  port N write data.
REQ-010 pN_gnt  out  1  port N request accepted this cycle (combinational).
REQ-011 pN_rvalid  out  1  port N read data valid, registered.
REQ-012 pN_rdata  out  DATA_W  port N read data, qualified by pN_rvalid.
REQ-013 p1_lock  in  1  port 1 keeps ownership for back-to-back transfers while asserted.
REQ-014 mem_addr  out  ADDR_W  address to the synchronous single-port memory.
REQ-015 mem_strobe  out  1  memory access enable; the memory samples it on the rising edge.
REQ-016 mem_we  out  1  memory write enable, valid with mem_strobe.
REQ-017 mem_wdata  out  DATA_W  memory write data.
REQ-018 mem_rdata  in  DATA_W  memory read data, valid one cycle after a read strobe.

Function
REQ-019 At most one pN_gnt is high per cycle; mem_strobe = p0_gnt | p1_gnt.
REQ-020 mem_addr, mem_we and mem_wdata are muxed from the granted port; when no port is granted they are driven from port 0 and mem_strobe is 0.
REQ-021 A grant is issued in the same cycle as the request when the arbiter is not owned by another port; the transfer completes in that cycle.
REQ-022 Read latency: the granted read in cycle N gives pN_rvalid=1 in cycle N+1, with pN_rdata = mem_rdata; pN_rvalid is high for exactly one cycle per granted read.
REQ-023 A granted write produces no rvalid.
REQ-024 Round-robin: register last_owner (reset 1); with both ports requesting, the port not equal to last_owner is granted; last_owner updates on every grant.
REQ-025 FIXED_PRIO=1: port 0 wins every conflict and last_owner is ignored.
REQ-026 Lock: when port 1 is granted with p1_lock=1, state goes IDLE->LOCKED; in LOCKED only port 1 can be granted; LOCKED->IDLE on the first cycle p1_lock=0.
REQ-027 In LOCKED, p0_req stays pending (p0_gnt=0) and p0 has no timeout.
REQ-028 A single requester is granted every cycle it requests, giving one transfer per cycle.
REQ-029 With both ports continuously requesting in round-robin mode, grants alternate 0,1,0,1 and no port waits more than 1 cycle.
REQ-030 If a port's req drops while it is waiting, nothing is recorded; there is no request queue.

Reset
REQ-031 While reset_n=0 at a clock edge: state=IDLE, last_owner=1, p0_rvalid=p1_rvalid=0; any pending read return is discarded.
REQ-032 While reset_n=0, grants and mem_strobe are forced to 0.
REQ-033 Reset has priority over all other events in the same cycle, including a lock request.

Structure
REQ-034 Arbiter state encoding (IDLE, LOCKED) and the port-index constants live in the shared package with the processor state constants.
REQ-035 There is one optional sub-module, rr_pick: a pure 2-way round-robin selector with inputs req[1:0], last and output grant one-hot.
REQ-036 The processor instruction fetch connects to port 0 and the debug loader connects to port 1.

Verification
REQ-037 Reset, then p0 reads addr 0x02 alone -> p0_gnt in same cycle, next cycle p0_rvalid=1 and p0_rdata=mem[0x02]=0x1C.
REQ-038 Both ports read (p0 0x00, p1 0x05) for 4 cycles -> grants go p0,p1,p0,p1 and each rvalid goes to the port that issued the read.
REQ-039 p1 writes 0xAA to 0x10 with p1_lock=1 for 3 cycles while p0 requests -> p0_gnt=0 for 3 cycles; p0 is granted in the cycle lock drops; a later p0 read of 0x10 returns 0xAA.
REQ-040 FIXED_PRIO=1 with both ports requesting for 5 cycles -> p0 is granted 5 times and p1 0 times.
REQ-041 reset_n=0 in the cycle after a granted read -> no rvalid is seen, and after release state=IDLE and p0 wins the first conflict.
REQ-042 Random requests over 10k cycles -> never two grants in one cycle, every granted read gets exactly one rvalid, and no read data goes to the wrong port.
